// File: rtl/snn_pkg.sv
// Shared types and defaults for the spiking-neuron datapath.
package snn_pkg;

    localparam int SUM_W_DEF   = 19;
    localparam int POT_W_DEF   = 24;
    localparam int SPIKE_CNT_W = 16;

    // Neuron control states; exported on state_dbg for observation.
    typedef enum logic [1:0] {
        INTEGRATE = 2'd0,
        FIRE      = 2'd1,
        REFRAC    = 2'd2
    } lif_state_e;

endpackage

// File: rtl/lif_update.sv
// Combinational membrane update: leak, add the new sum, clamp, compare to threshold.
module lif_update #(
    parameter int SUM_W      = 19,
    parameter int POT_W      = 24,
    parameter int LEAK_SHIFT = 4
) (
    input  logic [POT_W-1:0] v,
    input  logic [SUM_W-1:0] sum,
    input  logic [POT_W-1:0] threshold,
    output logic [POT_W-1:0] v_next,
    output logic             fire
);

    logic [POT_W:0] v_ext;
    logic [POT_W:0] leak;
    logic [POT_W:0] acc;

    // One extra bit catches overflow of the add; leak never exceeds v so no underflow.
    always_comb begin
        v_ext  = {1'b0, v};
        leak   = v_ext >> LEAK_SHIFT;
        acc    = v_ext - leak + {{(POT_W + 1 - SUM_W){1'b0}}, sum};
        v_next = acc[POT_W] ? {POT_W{1'b1}} : acc[POT_W-1:0];
        fire   = (v_next >= threshold);
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: FSM, refractory counter and spike counter
// around the combinational lif_update datapath.
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready
// and clear is low. in_ready depends only on state, never on in_valid; a
// sample offered while in_ready is low is not consumed and must be held or
// re-presented by the producer.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int SUM_W         = SUM_W_DEF,
    parameter int POT_W         = POT_W_DEF,
    parameter int LEAK_SHIFT    = 4,
    parameter int REFRAC_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SUM_W-1:0]       sum,
    input  logic [POT_W-1:0]       threshold,
    input  logic                   clear,
    output logic                   spike,
    output logic [POT_W-1:0]       potential,
    output logic                   refractory,
    output logic [SPIKE_CNT_W-1:0] spike_count,
    output lif_state_e             state_dbg
);

    localparam int CNT_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

    lif_state_e             state_q, state_d;
    logic [POT_W-1:0]       pot_q, pot_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   spike_q, spike_d;
    logic [SPIKE_CNT_W-1:0] scnt_q, scnt_d;

    logic [POT_W-1:0]       v_next;
    logic                   fire;
    logic                   accept;

    lif_update #(
        .SUM_W      (SUM_W),
        .POT_W      (POT_W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .v         (pot_q),
        .sum       (sum),
        .threshold (threshold),
        .v_next    (v_next),
        .fire      (fire)
    );

    assign in_ready    = (state_q == INTEGRATE);
    assign refractory  = (state_q != INTEGRATE);
    assign accept      = in_valid & in_ready & ~clear;
    assign spike       = spike_q;
    assign potential   = pot_q;
    assign spike_count = scnt_q;
    assign state_dbg   = state_q;

    // State, potential, counters and spike pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INTEGRATE;
            pot_q   <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pot_q   <= pot_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
            scnt_q  <= scnt_d;
        end
    end

    // Next-state logic; clear overrides everything and drops any offered sample.
    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        scnt_d  = scnt_q;
        if (clear) begin
            state_d = INTEGRATE;
            pot_d   = '0;
            cnt_d   = '0;
            scnt_d  = '0;
        end else begin
            case (state_q)
                INTEGRATE: begin
                    if (accept) begin
                        if (fire) begin
                            pot_d   = '0;
                            state_d = FIRE;
                            spike_d = 1'b1;
                            scnt_d  = (scnt_q == {SPIKE_CNT_W{1'b1}}) ? scnt_q : scnt_q + 1'b1;
                        end else begin
                            pot_d = v_next;
                        end
                    end
                end
                FIRE: begin
                    if (REFRAC_CYCLES == 0) begin
                        state_d = INTEGRATE;
                    end else begin
                        state_d = REFRAC;
                        cnt_d   = CNT_W'(REFRAC_CYCLES);
                    end
                end
                REFRAC: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = INTEGRATE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = INTEGRATE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: three instances (default, no refractory, slow leak)
// share one stimulus stream and are compared each cycle with a reference model.
module tb_lif_neuron;
    import snn_pkg::*;

    localparam int N = 3;
    localparam longint VMAX = 64'h0000_0000_00FF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [18:0] sum;
    logic [23:0] threshold;
    logic        clear;

    logic        rdy_o  [N];
    logic        spk_o  [N];
    logic [23:0] pot_o  [N];
    logic        ref_o  [N];
    logic [15:0] cnt_o  [N];
    lif_state_e  st_o   [N];

    lif_neuron #(.LEAK_SHIFT(4), .REFRAC_CYCLES(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[0]),
        .sum(sum), .threshold(threshold), .clear(clear), .spike(spk_o[0]),
        .potential(pot_o[0]), .refractory(ref_o[0]), .spike_count(cnt_o[0]),
        .state_dbg(st_o[0]));
    lif_neuron #(.LEAK_SHIFT(4), .REFRAC_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[1]),
        .sum(sum), .threshold(threshold), .clear(clear), .spike(spk_o[1]),
        .potential(pot_o[1]), .refractory(ref_o[1]), .spike_count(cnt_o[1]),
        .state_dbg(st_o[1]));
    lif_neuron #(.LEAK_SHIFT(8), .REFRAC_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[2]),
        .sum(sum), .threshold(threshold), .clear(clear), .spike(spk_o[2]),
        .potential(pot_o[2]), .refractory(ref_o[2]), .spike_count(cnt_o[2]),
        .state_dbg(st_o[2]));

    // Reference model: per-instance parameters and behavioural state.
    // busy = cycles remaining during which the neuron refuses samples.
    int     m_refrac [N] = '{3, 0, 3};
    int     m_shift  [N] = '{4, 4, 8};
    longint m_v      [N];
    int     m_busy   [N];
    bit     m_spk    [N];
    int     m_cnt    [N];
    int     m_spikes_seen;

    int vectors;
    int errors;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_busy[i] = 0; m_spk[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge(input bit v_in, input longint s, input longint thr, input bit clr);
        longint nv;
        for (int i = 0; i < N; i++) begin
            if (clr) begin
                m_v[i] = 0; m_busy[i] = 0; m_spk[i] = 0; m_cnt[i] = 0;
            end else if (m_busy[i] == 0 && v_in) begin
                nv = m_v[i] - m_v[i] / (64'd1 << m_shift[i]) + s;
                if (nv > VMAX) nv = VMAX;
                if (nv >= thr) begin
                    m_v[i]    = 0;
                    m_busy[i] = 1 + m_refrac[i];
                    m_spk[i]  = 1;
                    if (m_cnt[i] < 65535) m_cnt[i]++;
                end else begin
                    m_v[i]   = nv;
                    m_spk[i] = 0;
                end
            end else begin
                m_spk[i] = 0;
                if (m_busy[i] > 0) m_busy[i]--;
            end
        end
    endtask

    task automatic check(input string tag, input int idx, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check("in_ready",    i, longint'(rdy_o[i]), longint'(m_busy[i] == 0));
            check("refractory",  i, longint'(ref_o[i]), longint'(m_busy[i] != 0));
            check("spike",       i, longint'(spk_o[i]), longint'(m_spk[i]));
            check("potential",   i, longint'(pot_o[i]), m_v[i]);
            check("spike_count", i, longint'(cnt_o[i]), longint'(m_cnt[i]));
            if (spk_o[i] === 1'b1) m_spikes_seen++;
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check 1 ns later.
    task automatic step(input bit v_in, input logic [18:0] s, input logic [23:0] thr, input bit clr);
        in_valid  = v_in;
        sum       = s;
        threshold = thr;
        clear     = clr;
        @(posedge clk);
        model_edge(v_in, longint'(s), longint'(thr), clr);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input logic [23:0] thr);
        for (int k = 0; k < n; k++) step(1'b0, '0, thr, 1'b0);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        m_spikes_seen = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sum       = '0;
        threshold = 24'd20;
        clear     = 1'b0;
        model_reset();

        // Reset state observed while reset is held.
        #12;
        check_all();
        rst_n = 1'b1;
        idle(2, 24'd20);

        // Accumulate and fire: 7, 14, 21 >= 20.
        for (int k = 0; k < 3; k++) step(1'b1, 19'd7, 24'd20, 1'b0);
        check("directed_count_after_fire", 0, longint'(cnt_o[0]), 64'd1);
        idle(6, 24'd20);

        // Leak: 160, 150, 141 with no spike.
        step(1'b0, '0, 24'd1000, 1'b1);
        step(1'b1, 19'd160, 24'd1000, 1'b0);
        step(1'b1, 19'd0,   24'd1000, 1'b0);
        step(1'b1, 19'd0,   24'd1000, 1'b0);
        check("directed_leak", 0, longint'(pot_o[0]), 64'd141);
        idle(2, 24'd1000);

        // Refractory drop: valid held for 10 cycles.
        step(1'b0, '0, 24'd20, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b1, 19'd25, 24'd20, 1'b0);
        idle(5, 24'd20);

        // Saturation: clamps at full scale on the slow-leak instance and fires.
        step(1'b0, '0, 24'hFFFFFF, 1'b1);
        for (int k = 0; k < 60; k++) step(1'b1, 19'h7FFFF, 24'hFFFFFF, 1'b0);
        idle(5, 24'hFFFFFF);

        // Clear during FIRE, then fire again after 7 x3.
        step(1'b0, '0, 24'd20, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 19'd7, 24'd20, 1'b0);
        step(1'b1, 19'd7, 24'd20, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 19'd7, 24'd20, 1'b0);
        idle(5, 24'd20);

        // Asynchronous reset mid-REFRAC, checked before the next clock edge.
        step(1'b0, '0, 24'd20, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 19'd7, 24'd20, 1'b0);
        step(1'b0, '0, 24'd20, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, 19'd7, 24'd20, 1'b0);
        idle(5, 24'd20);

        // Random traffic with varying thresholds and occasional clear.
        for (int k = 0; k < 400; k++) begin
            logic [18:0] s;
            logic [23:0] thr;
            int sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0: thr = 24'd0;
                1: thr = 24'($urandom_range(1, 200));
                2: thr = 24'($urandom_range(1000, 2000000));
                default: thr = 24'hFFFFFF;
            endcase
            s = ($urandom_range(0, 3) == 0) ? 19'($urandom) : 19'($urandom_range(0, 60));
            step(($urandom_range(0, 3) != 0), s, thr, ($urandom_range(0, 49) == 0));
        end

        check("spikes_observed_nonzero", 0, longint'(m_spikes_seen > 10), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
